ps2_keyboard_rx: RTL and testbench



---
 rtl/ps2_keyboard_rx.sv | 160 ++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receive front end: synchronises and filters the raw pins,
// deserialises 11-bit device-to-host frames and strobes out good scan bytes.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 24000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] scan,
    output logic       scan_received,
    output logic       rx_error
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    localparam int              TO_W     = 21;
    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT);
    localparam logic [7:0]      FILT_MAX = 8'(FILTER_LEN - 1);

    logic            clk_meta_p0, clk_sync_p1, data_meta_p0, data_sync_p1;
    logic [7:0]      clk_cnt, data_cnt;
    logic            clk_filt_p2, data_filt_p2, clk_filt_d_p3;
    logic            fall;
    logic [1:0]      state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_p3;
    logic            parity_bit;
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;
    logic            good_p4;

    // Stage p0/p1: two-flop synchronisers, idle-high
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta_p0  <= 1'b1;
            clk_sync_p1  <= 1'b1;
            data_meta_p0 <= 1'b1;
            data_sync_p1 <= 1'b1;
        end else begin
            clk_meta_p0  <= ps2clk;
            clk_sync_p1  <= clk_meta_p0;
            data_meta_p0 <= ps2data;
            data_sync_p1 <= data_meta_p0;
        end
    end

    // Stage p2: level flips only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt     <= 8'd0;
            clk_filt_p2 <= 1'b1;
        end else if (clk_sync_p1 != clk_filt_p2) begin
            if (clk_cnt == FILT_MAX) begin
                clk_filt_p2 <= clk_sync_p1;
                clk_cnt     <= 8'd0;
            end else begin
                clk_cnt <= clk_cnt + 8'd1;
            end
        end else begin
            clk_cnt <= 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_cnt     <= 8'd0;
            data_filt_p2 <= 1'b1;
        end else if (data_sync_p1 != data_filt_p2) begin
            if (data_cnt == FILT_MAX) begin
                data_filt_p2 <= data_sync_p1;
                data_cnt     <= 8'd0;
            end else begin
                data_cnt <= data_cnt + 8'd1;
            end
        end else begin
            data_cnt <= 8'd0;
        end
    end

    // Stage p3: falling-edge detect on the filtered clock
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt_d_p3 <= 1'b1;
        end else begin
            clk_filt_d_p3 <= clk_filt_p2;
        end
    end

    assign fall   = clk_filt_d_p3 & ~clk_filt_p2;
    assign to_hit = (state != S_IDLE) && (to_cnt == TO_MAX);

    always_ff @(posedge clk) begin
        if (fall && state == S_DATA) begin
            shift_p3 <= {data_filt_p2, shift_p3[7:1]};
        end
    end

    // Stage p4: frame FSM; scan registers one cycle ahead of its strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            bit_cnt       <= 3'd0;
            parity_bit    <= 1'b0;
            to_cnt        <= '0;
            scan          <= 8'h00;
            good_p4       <= 1'b0;
            scan_received <= 1'b0;
            rx_error      <= 1'b0;
        end else begin
            good_p4       <= 1'b0;
            rx_error      <= 1'b0;
            scan_received <= good_p4;

            if (state == S_IDLE || fall) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (fall) begin
                case (state)
                    S_IDLE: begin
                        if (!data_filt_p2) begin
                            bit_cnt <= 3'd0;
                            state   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        parity_bit <= data_filt_p2;
                        state      <= S_STOP;
                    end
                    default: begin
                        if (data_filt_p2 && ((^shift_p3) ^ parity_bit)) begin
                            scan    <= shift_p3;
                            good_p4 <= 1'b1;
                        end else begin
                            rx_error <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                endcase
            end else if (to_hit) begin
                rx_error <= 1'b1;
                state    <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: table-driven frames, corner-case
// sequences and randomized frames checked against a frame-level model.
module tb_ps2_keyboard_rx;

    localparam int FL   = 4;
    localparam int TO   = 200;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2clk;
    logic       ps2data;
    logic [7:0] scan;
    logic       scan_received;
    logic       rx_error;

    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .ps2clk        (ps2clk),
        .ps2data       (ps2data),
        .scan          (scan),
        .scan_received (scan_received),
        .rx_error      (rx_error)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         ev_q[$];
    int         stop_cyc = 0;
    bit         lat_armed = 0;
    logic [7:0] scan_prev = 8'h00;
    logic [7:0] model_scan = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: records strobes as byte values, errors as -1
    always @(negedge clk) begin
        if (scan_received || rx_error) begin
            n_vec++;
            if (scan_received && rx_error) begin
                n_bad++;
                $display("FAIL both_strobes: scan_received=1 rx_error=1, required not both");
            end
            if (scan_received) begin
                n_vec++;
                if (scan !== scan_prev) begin
                    n_bad++;
                    $display("FAIL scan_setup: scan before strobe %02h, required %02h", scan_prev, scan);
                end
                ev_q.push_back(int'(scan));
            end else begin
                ev_q.push_back(-1);
            end
            if (lat_armed) begin
                int exp_lat;
                exp_lat = scan_received ? FL + 4 : FL + 3;
                n_vec++;
                if (cyc - stop_cyc != exp_lat) begin
                    n_bad++;
                    $display("FAIL latency: %0d cycles after stop edge, required %0d", cyc - stop_cyc, exp_lat);
                end
                lat_armed = 0;
            end
        end
        scan_prev = scan;
    end

    task automatic send_bit(input logic b, input bit is_stop);
        @(negedge clk);
        ps2data = b;
        repeat (HALF) @(negedge clk);
        ps2clk = 1'b0;
        if (is_stop) begin
            stop_cyc  = cyc;
            lat_armed = 1;
        end
        repeat (HALF) @(negedge clk);
        ps2clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 0);
        send_bit(par, 0);
        send_bit(stop, 1);
        ps2data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic check_event(input int exp, input string name);
        int got;
        n_vec++;
        if (ev_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: no event, required %0d", name, exp);
        end else begin
            got = ev_q.pop_front();
            if (got != exp) begin
                n_bad++;
                $display("FAIL %s: event %0d, required %0d", name, got, exp);
            end
        end
    endtask

    task automatic check_none(input string name);
        n_vec++;
        if (ev_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d unexpected events (first %0d), required 0", name, ev_q.size(), ev_q[0]);
            ev_q.delete();
        end
    endtask

    task automatic check_val(input logic [7:0] act, input logic [7:0] exp, input string name);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, required %02h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         exp_ev;
        logic [7:0] exp_scan;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [7:0] d;
        logic       par;
        logic       stop;
        int         exp;

        tbl[0] = '{8'h1C, 1'b0, 1'b1, 'h1C, 8'h1C};
        tbl[1] = '{8'h12, 1'b0, 1'b1, -1,   8'h1C};
        tbl[2] = '{8'hF0, 1'b1, 1'b1, 'hF0, 8'hF0};
        tbl[3] = '{8'h1C, 1'b0, 1'b1, 'h1C, 8'h1C};
        tbl[4] = '{8'h1C, 1'b0, 1'b0, -1,   8'h1C};
        tbl[5] = '{8'h00, 1'b1, 1'b1, 'h00, 8'h00};
        tbl[6] = '{8'hFF, 1'b1, 1'b1, 'hFF, 8'hFF};
        tbl[7] = '{8'h29, 1'b0, 1'b1, 'h29, 8'h29};
        tbl[8] = '{8'h5A, 1'b0, 1'b1, -1,   8'h29};
        tbl[9] = '{8'h80, 1'b0, 1'b1, 'h80, 8'h80};

        rst = 1'b1;
        ps2clk = 1'b1;
        ps2data = 1'b1;
        repeat (3) @(negedge clk);
        check_val(scan, 8'h00, "reset_scan");
        check_val({7'd0, scan_received}, 8'h00, "reset_strobe");
        check_val({7'd0, rx_error}, 8'h00, "reset_error");
        rst = 1'b0;
        repeat (HALF) @(negedge clk);

        // Sub-threshold clock glitch while idle
        ps2clk = 1'b0;
        repeat (FL - 1) @(negedge clk);
        ps2clk = 1'b1;
        repeat (HALF) @(negedge clk);
        check_none("glitch_idle");

        for (int i = 0; i < 10; i++) begin
            send_frame(tbl[i].data, tbl[i].par, tbl[i].stop);
            check_event(tbl[i].exp_ev, $sformatf("table%0d_event", i));
            check_val(scan, tbl[i].exp_scan, $sformatf("table%0d_scan", i));
        end

        // Timeout: start + 4 data bits, then the clock stalls high
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(i[0], 0);
        repeat (TO + 10) @(negedge clk);
        check_event(-1, "timeout_error");
        check_val(scan, 8'h80, "timeout_scan_held");
        send_frame(8'h29, 1'b0, 1'b1);
        check_event('h29, "after_timeout_event");
        check_val(scan, 8'h29, "after_timeout_scan");

        // Sub-threshold clock glitch mid-frame
        d = 8'h3C;
        send_bit(1'b0, 0);
        for (int i = 0; i < 3; i++) send_bit(d[i], 0);
        @(negedge clk);
        ps2clk = 1'b0;
        repeat (FL - 1) @(negedge clk);
        ps2clk = 1'b1;
        repeat (HALF) @(negedge clk);
        for (int i = 3; i < 8; i++) send_bit(d[i], 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 1);
        repeat (HALF) @(negedge clk);
        check_event('h3C, "glitch_mid_event");
        check_val(scan, 8'h3C, "glitch_mid_scan");

        // Reset after the 5th data bit
        d = 8'h77;
        send_bit(1'b0, 0);
        for (int i = 0; i < 5; i++) send_bit(d[i], 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val(scan, 8'h00, "midrst_scan");
        check_val({7'd0, scan_received}, 8'h00, "midrst_strobe");
        check_val({7'd0, rx_error}, 8'h00, "midrst_error");
        repeat (4 * HALF) @(negedge clk);
        check_none("midrst_quiet");
        send_frame(8'h5A, 1'b1, 1'b1);
        check_event('h5A, "after_rst_event");
        check_val(scan, 8'h5A, "after_rst_scan");
        model_scan = 8'h5A;

        // Randomized frames against the frame-level model
        for (int i = 0; i < 30; i++) begin
            d    = 8'($urandom);
            par  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 4) == 0) par = ~par;
            stop = ($urandom_range(0, 7) != 0);
            if (stop && (($countones(d) + int'(par)) % 2 == 1)) begin
                exp = int'(d);
                model_scan = d;
            end else begin
                exp = -1;
            end
            send_frame(d, par, stop);
            check_event(exp, $sformatf("rand%0d_event", i));
            check_val(scan, model_scan, $sformatf("rand%0d_scan", i));
        end

        repeat (2 * HALF) @(negedge clk);
        check_none("final_quiet");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
